// File: rtl/sc_io_device.sv
// Board I/O block: synchronises and debounces switches/keys for the CPU,
// latches key-press flags, drives LEDs and an 8-digit multiplexed hex display.
module sc_io_device #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    input  logic [31:0] out_port0,
    input  logic [31:0] out_port1,
    output logic [31:0] in_port0,
    output logic [31:0] in_port1,
    output logic [6:0]  hex_seg,
    output logic [7:0]  hex_sel,
    output logic [9:0]  led
);

    localparam int NB = 14;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // Keys idle high (released), switches idle low.
    localparam logic [NB-1:0] IDLE = {4'hF, 10'h000};

    logic [NB-1:0] sync1, sync2, stable, stable_next;
    logic [CW-1:0] cnt      [NB];
    logic [CW-1:0] cnt_next [NB];
    logic [3:0]    flag, flag_next, press_rise;
    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [31:0]   disp;
    logic [3:0]    nibble;
    logic          unused_ctrl;

    assign unused_ctrl = ^out_port1[29:10];

    always_comb begin
        stable_next = stable;
        for (int unsigned i = 0; i < NB; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1))
                    stable_next[i] = sync2[i];
                else
                    cnt_next[i] = cnt[i] + 1'b1;
            end
        end
    end

    // A press detected on the same edge as a clear must survive the clear.
    always_comb begin
        press_rise = stable[13:10] & ~stable_next[13:10];
        flag_next  = (out_port1[31] ? 4'h0 : flag) | press_rise;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1  <= IDLE;
            sync2  <= IDLE;
            stable <= IDLE;
            for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
            flag   <= '0;
            led    <= '0;
        end else begin
            sync1  <= {key, sw};
            sync2  <= sync1;
            stable <= stable_next;
            for (int unsigned i = 0; i < NB; i++) cnt[i] <= cnt_next[i];
            flag   <= flag_next;
            led    <= out_port1[9:0];
        end
    end

    // Display word is only taken at the 7->0 wrap so a frame never mixes words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div  <= '0;
            idx  <= '0;
            disp <= '0;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + 3'd1;
            if (idx == 3'd7) disp <= out_port0;
        end else begin
            div <= div + 1'b1;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        nibble   = disp[4*idx +: 4];
        hex_seg  = glyph(nibble);
        hex_sel  = out_port1[30] ? 8'hFF : ~(8'h01 << idx);
        in_port0 = {22'b0, stable[9:0]};
        in_port1 = {24'b0, flag, ~stable[13:10]};
    end

endmodule
